// File: rtl/fa_fault_detector.sv
// fa_fault_detector: runs a golden gate-level full adder and a copy with one
// selectable stuck-at fault on the same registered inputs. Sum and carry
// disagreements are reported as registered flags. A sticky "fault seen" bit
// and a saturating detection counter are also kept.
// Stage 1 captures the inputs. Stage 2 compares the two adders and registers
// the result, so outputs appear two rising edges after the inputs are applied.
module fa_fault_detector (
  input  logic       clk,
  input  logic       rst,
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [2:0] fault_select,
  output logic       fault_sum_detected,
  output logic       fault_carry_detected,
  output logic       fault_seen,
  output logic [7:0] detect_count
);

  // Every encodable fault code has a meaning, so the enum covers all 3-bit values.
  typedef enum logic [2:0] {
    FAULT_NONE     = 3'd0,
    FAULT_SUM_SA0  = 3'd1,
    FAULT_SUM_SA1  = 3'd2,
    FAULT_COUT_SA0 = 3'd3,
    FAULT_COUT_SA1 = 3'd4,
    FAULT_N1_SA0   = 3'd5,
    FAULT_N1_SA1   = 3'd6,
    FAULT_N2_SA0   = 3'd7
  } faultCode_t;

  logic       r_a;
  logic       r_b;
  logic       r_cin;
  faultCode_t r_faultSel;

  logic       r_sumDet;
  logic       r_carryDet;
  logic       r_seen;
  logic [7:0] r_count;

  logic w_goldN1;
  logic w_goldN2;
  logic w_goldN3;
  logic w_goldSum;
  logic w_goldCout;

  logic w_faultN1;
  logic w_faultN2;
  logic w_faultN3;
  logic w_faultSum;
  logic w_faultCout;

  logic w_sumDiff;
  logic w_carryDiff;
  logic w_anyDiff;

  // Stage 1: capture the operands and the fault code.
  // On reset the fault code returns to "no fault".
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a        <= 1'b0;
      r_b        <= 1'b0;
      r_cin      <= 1'b0;
      r_faultSel <= FAULT_NONE;
    end else begin
      r_a        <= a;
      r_b        <= b;
      r_cin      <= cin;
      r_faultSel <= faultCode_t'(fault_select);
    end
  end

  // Golden adder: the plain gate network. It is never faulted.
  always_comb begin
    w_goldN1   = r_a ^ r_b;
    w_goldN2   = r_a & r_b;
    w_goldN3   = w_goldN1 & r_cin;
    w_goldSum  = w_goldN1 ^ r_cin;
    w_goldCout = w_goldN2 | w_goldN3;
  end

  // Faulty adder: the same gate network, with the selected node overridden.
  // An n1 fault is applied before n3 and sum are formed, so it reaches both.
  always_comb begin
    w_faultN1 = r_a ^ r_b;
    if (r_faultSel == FAULT_N1_SA0) begin
      w_faultN1 = 1'b0;
    end else if (r_faultSel == FAULT_N1_SA1) begin
      w_faultN1 = 1'b1;
    end

    w_faultN2 = r_a & r_b;
    if (r_faultSel == FAULT_N2_SA0) begin
      w_faultN2 = 1'b0;
    end

    w_faultN3 = w_faultN1 & r_cin;

    w_faultSum = w_faultN1 ^ r_cin;
    if (r_faultSel == FAULT_SUM_SA0) begin
      w_faultSum = 1'b0;
    end else if (r_faultSel == FAULT_SUM_SA1) begin
      w_faultSum = 1'b1;
    end

    w_faultCout = w_faultN2 | w_faultN3;
    if (r_faultSel == FAULT_COUT_SA0) begin
      w_faultCout = 1'b0;
    end else if (r_faultSel == FAULT_COUT_SA1) begin
      w_faultCout = 1'b1;
    end
  end

  // Compare the two adders. A set bit means the fault is visible on that output.
  always_comb begin
    w_sumDiff   = w_goldSum ^ w_faultSum;
    w_carryDiff = w_goldCout ^ w_faultCout;
    w_anyDiff   = w_sumDiff | w_carryDiff;
  end

  // Stage 2: register the flags. The sticky bit and the counter use the flags
  // computed this cycle. Reset takes priority over both of them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sumDet   <= 1'b0;
      r_carryDet <= 1'b0;
      r_seen     <= 1'b0;
      r_count    <= 8'd0;
    end else begin
      r_sumDet   <= w_sumDiff;
      r_carryDet <= w_carryDiff;
      if (w_anyDiff) begin
        r_seen <= 1'b1;
      end
      if (w_anyDiff && (r_count != 8'hFF)) begin
        r_count <= r_count + 8'd1;
      end
    end
  end

  assign fault_sum_detected   = r_sumDet;
  assign fault_carry_detected = r_carryDet;
  assign fault_seen           = r_seen;
  assign detect_count         = r_count;

endmodule

// File: tb/tb_fa_fault_detector.sv
// tb_fa_fault_detector: scoreboard bench for fa_fault_detector.
// The driver applies one vector per negative edge and queues the detection
// flags that the reference model predicts. The monitor follows the two-edge
// pipeline. It pops an entry whenever a vector reaches the outputs and keeps
// the sticky and counter model itself.
module tb_fa_fault_detector;

  logic       clk;
  logic       rst;
  logic       a;
  logic       b;
  logic       cin;
  logic [2:0] fault_select;
  logic       fault_sum_detected;
  logic       fault_carry_detected;
  logic       fault_seen;
  logic [7:0] detect_count;

  int total = 0;
  int bad   = 0;

  // {carry flag, sum flag} predicted for each applied vector, in order.
  logic [1:0] expQ[$];

  // Set by the driver while the inputs hold a vector that has been queued.
  logic drv = 1'b0;

  int mSeen  = 0;
  int mCount = 0;

  fa_fault_detector fault_detector (
    .clk                  (clk),
    .rst                  (rst),
    .a                    (a),
    .b                    (b),
    .cin                  (cin),
    .fault_select         (fault_select),
    .fault_sum_detected   (fault_sum_detected),
    .fault_carry_detected (fault_carry_detected),
    .fault_seen           (fault_seen),
    .detect_count         (detect_count)
  );

  // 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model. It works from the arithmetic meaning of the adder and
  // from what each stuck node does to the final outputs.
  function automatic logic [1:0] refDetect(input int ai, input int bi, input int ci, input int fs);
    int tot;
    int goldSum;
    int goldCout;
    int badSum;
    int badCout;
    tot      = ai + bi + ci;
    goldSum  = tot % 2;
    goldCout = tot / 2;
    badSum   = goldSum;
    badCout  = goldCout;
    case (fs)
      1: badSum  = 0;
      2: badSum  = 1;
      3: badCout = 0;
      4: badCout = 1;
      5: begin
        badSum  = ci;
        badCout = ai & bi;
      end
      6: begin
        badSum  = 1 - ci;
        badCout = (ai & bi) | ci;
      end
      7: badCout = (ai != bi && ci == 1) ? 1 : 0;
      default: ;
    endcase
    return {logic'(goldCout != badCout), logic'(goldSum != badSum)};
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s got=%0d want=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int ai, input int bi, input int ci, input int fs);
    @(negedge clk);
    rst          = 1'b0;
    a            = ai[0];
    b            = bi[0];
    cin          = ci[0];
    fault_select = fs[2:0];
    drv          = 1'b1;
    expQ.push_back(refDetect(ai, bi, ci, fs));
  endtask

  task automatic applyReset(input int edges);
    @(negedge clk);
    rst = 1'b1;
    drv = 1'b0;
    repeat (edges - 1) @(negedge clk);
  endtask

  // Monitor: follows which edges carry a queued vector to the outputs.
  // A reset edge empties the pipeline and the model.
  initial begin
    logic v1;
    logic v2;
    logic sampRst;
    logic [1:0] e;
    v1 = 1'b0;
    v2 = 1'b0;
    forever begin
      @(posedge clk);
      sampRst = rst;
      v2 = v1;
      v1 = drv;
      if (sampRst) begin
        v1 = 1'b0;
        v2 = 1'b0;
        expQ.delete();
        mSeen  = 0;
        mCount = 0;
      end
      #1;
      if (sampRst) begin
        checkOutput("rstSum", int'(fault_sum_detected), 0);
        checkOutput("rstCarry", int'(fault_carry_detected), 0);
        checkOutput("rstSeen", int'(fault_seen), 0);
        checkOutput("rstCount", int'(detect_count), 0);
      end else if (v2) begin
        if (expQ.size() == 0) begin
          checkOutput("queueUnderflow", 1, 0);
        end else begin
          e = expQ.pop_front();
          if (e != 2'b00) begin
            mSeen = 1;
            if (mCount < 255) mCount++;
          end
          checkOutput("sumDet", int'(fault_sum_detected), int'(e[0]));
          checkOutput("carryDet", int'(fault_carry_detected), int'(e[1]));
          checkOutput("seen", int'(fault_seen), mSeen);
          checkOutput("count", int'(detect_count), mCount);
        end
      end
    end
  end

  // Watchdog: the run must always reach its summary line.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Driver: the test phases in order.
  initial begin
    rst          = 1'b1;
    a            = 1'b0;
    b            = 1'b0;
    cin          = 1'b0;
    fault_select = 3'd0;
    applyReset(2);

    // All input combinations with no fault injected.
    for (int v = 0; v < 8; v++) applyStimulus(v[2], v[1], v[0], 0);

    // Directed cases for individual stuck nodes.
    applyStimulus(1, 0, 0, 1);
    applyStimulus(1, 1, 0, 1);
    applyStimulus(0, 0, 0, 4);
    applyStimulus(1, 1, 0, 4);
    applyStimulus(0, 1, 1, 3);
    applyStimulus(1, 0, 1, 5);
    applyStimulus(0, 0, 1, 6);
    applyStimulus(1, 1, 0, 7);

    // Every fault code against every input combination.
    for (int fs = 0; fs < 8; fs++) begin
      for (int v = 0; v < 8; v++) applyStimulus(v[2], v[1], v[0], fs);
    end

    // Random vectors.
    for (int i = 0; i < 150; i++) begin
      applyStimulus(int'($urandom_range(1, 0)), int'($urandom_range(1, 0)),
                    int'($urandom_range(1, 0)), int'($urandom_range(7, 0)));
    end

    // Saturation: sum stuck-at-1 on 0,0,0 is detected on every cycle.
    applyReset(1);
    for (int i = 0; i < 300; i++) applyStimulus(0, 0, 0, 2);

    // A single reset edge in mid-stream, then the count starts again.
    applyReset(1);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 2);
    applyStimulus(1, 1, 1, 0);

    // Drain the pipeline.
    @(negedge clk);
    drv = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("queueEmpty", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fa_fault_detector.md
# fa_fault_detector

Fault-injection checker for a single-bit full adder. A golden gate-level full adder and a copy with one selectable stuck-at fault are evaluated on the same registered inputs. Their sum and carry are compared, and mismatches are reported as registered detection flags. The block also provides a sticky "fault ever seen" flag and a saturating detection counter. It is the DUT-side core of the adder fault-coverage experiment. The module is instantiated as `fault_detector`.

## Interface
- No parameters.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `a` in 1: adder operand A.
- `b` in 1: adder operand B.
- `cin` in 1: adder carry-in.
- `fault_select` in 3: fault code to inject (see Operation).
- `fault_sum_detected` out 1: golden sum differs from faulty sum.
- `fault_carry_detected` out 1: golden carry differs from faulty carry.
- `fault_seen` out 1: sticky OR of both detection flags since reset.
- `detect_count` out 8: number of cycles with either detection flag set; saturates at 255.

## Operation
- Gate-level adder model, used by both the golden and the faulty copies:
  - n1 = a^b
  - sum = n1^cin
  - n2 = a&b
  - n3 = n1&cin
  - cout = n2|n3
- Fault codes (faulty copy only; the golden copy is never faulted):
  - 0: no fault.
  - 1: sum stuck-at-0.
  - 2: sum stuck-at-1.
  - 3: cout stuck-at-0.
  - 4: cout stuck-at-1.
  - 5: n1 stuck-at-0. The fault propagates to both sum and n3.
  - 6: n1 stuck-at-1.
  - 7: n2 stuck-at-0.
- Exactly one fault is active per cycle, selected by the registered `fault_select`.
- Detection outputs:
  - `fault_sum_detected` = golden_sum XOR faulty_sum.
  - `fault_carry_detected` = golden_cout XOR faulty_cout.
- Sticky flag and counter:
  - `fault_seen` is set when either detection flag is computed as 1, and is cleared only by reset.
  - `detect_count` increments by 1 on each cycle in which the newly computed flags have at least one bit set.
  - At 255 the counter holds; it never wraps.

## Timing
- Stage 1: `a`, `b`, `cin` and `fault_select` are captured on rising edge N.
- Stage 2: the comparison is computed combinationally from the stage-1 registers and registered on edge N+1.
- Total latency from input change to detection outputs: 2 rising edges after the inputs are stable before edge N.
- `fault_seen` and `detect_count` update on the same edge as the detection outputs. They reflect the new flags, not the previous ones.
- Reset, while `rst` is high at a rising edge:
  - All pipeline registers clear to 0; the captured `fault_select` becomes 0, meaning no fault.
  - `fault_sum_detected`, `fault_carry_detected` and `fault_seen` become 0.
  - `detect_count` becomes 8'd0.
- Reset asserted mid-operation discards in-flight values. The first valid outputs after reset deassertion appear 2 edges after the first captured input.
- Reset has priority over counter increment and sticky set on the same edge.
- Inputs may change every cycle; the block is fully pipelined with throughput of 1 comparison per cycle.

## Test plan
- Reset and no-fault sweep:
  - Apply reset, then all 8 {a,b,cin} combinations with fault_select=0.
  - Required: all outputs 0 and `detect_count`=0 throughout.
- Sum stuck-at-0, fault_select=1:
  - a,b,cin=1,0,0 -> fs=1, fc=0.
  - a,b,cin=1,1,0 -> fs=0, fc=0.
- Carry stuck-at-1, fault_select=4:
  - 0,0,0 -> fc=1, fs=0.
  - 1,1,0 -> fc=0.
  - Also check fault_select=3 with 0,1,1 -> fc=1.
- Internal node faults:
  - fault_select=5 with 1,0,1 -> fs=1, fc=1.
  - fault_select=6 with 0,0,1 -> fs=1, fc=1.
  - fault_select=7 with 1,1,0 -> fs=0, fc=1.
- Full 8x8 sweep of inputs × fault codes, one vector per cycle:
  - Check every output 2 edges later against a reference model.
  - `detect_count` must equal the number of detecting vectors.
  - `fault_seen` must be 1 after the first detection.
- Saturation and reset mid-stream:
  - Hold fault_select=2 with 0,0,0 for 300 cycles -> `detect_count` stops at 255.
  - Then assert `rst` for one edge -> all outputs 0 on that edge.
  - The count restarts from 0.
